rv32i_decode_stage: RTL and testbench

Instruction decode stage and ID/EX pipeline register of the 5-stage RV32I pipelined core. It sits between the IF/ID register and the execute stage. It decodes a 32-bit instruction into the shared control enums (ALU operation, ALU operand selects, writeback select), sign-extends the immediate and reads the register file. It registers the result into the ID/EX bundle consumed by execute, and it also detects load-use hazards, issues stalls and inserts bubbles on stall or flush.

---
 rtl/rv32i_types_pkg.sv | 59 +++++
 rtl/rv32i_decoder.sv | 95 +++++++++
 rtl/rv32i_decode_stage.sv | 138 +++++++++++++
 tb/tb_rv32i_decode_stage.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/rv32i_types_pkg.sv
// rtl/rv32i_types_pkg.sv - shared RV32I control enums, opcodes and ID/EX control bundle
package rv32i_types_pkg;

  typedef enum logic [3:0] {
    ALU_NONE, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_B
  } ALU_op_options_t;

  typedef enum logic {OP_A_OPERAND_1, OP_A_PC} mux_ALU_operand_A_options_t;
  typedef enum logic {OP_B_OPERAND_2, OP_B_IMMEDIATE} mux_ALU_operand_B_options_t;
  typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MEMORY, WB_PC_PLUS_4} mux_writeback_options_t;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_t;

  typedef struct packed {
    ALU_op_options_t            alu_op;
    mux_ALU_operand_A_options_t op_a_sel;
    mux_ALU_operand_B_options_t op_b_sel;
    mux_writeback_options_t     wb_sel;
    logic                       mem_read;
    logic                       mem_write;
    logic                       branch;
    logic                       jump;
    logic                       illegal;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t ID_EX_BUBBLE = '{
    alu_op: ALU_NONE, op_a_sel: OP_A_OPERAND_1, op_b_sel: OP_B_OPERAND_2,
    wb_sel: WB_NONE, mem_read: 1'b0, mem_write: 1'b0, branch: 1'b0,
    jump: 1'b0, illegal: 1'b0
  };

  // alt selects SUB on funct3 000 and SRA on funct3 101
  function automatic ALU_op_options_t alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// rtl/rv32i_decoder.sv - combinational RV32I instruction decoder
module rv32i_decoder
  import rv32i_types_pkg::*;
(
  input  logic [31:0] instr_i,
  output id_ex_ctrl_t ctrl_o,
  output imm_type_t   imm_type_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       bad_f7;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  always_comb begin
    ctrl_o     = ID_EX_BUBBLE;
    imm_type_o = IMM_I;
    bad_f7     = 1'b0;
    case (opcode)
      OPC_LUI: begin
        imm_type_o      = IMM_U;
        ctrl_o.op_b_sel = OP_B_IMMEDIATE;
        ctrl_o.alu_op   = ALU_B;
        ctrl_o.wb_sel   = WB_ALU;
      end
      OPC_AUIPC: begin
        imm_type_o      = IMM_U;
        ctrl_o.op_a_sel = OP_A_PC;
        ctrl_o.op_b_sel = OP_B_IMMEDIATE;
        ctrl_o.alu_op   = ALU_ADD;
        ctrl_o.wb_sel   = WB_ALU;
      end
      OPC_JAL: begin
        imm_type_o      = IMM_J;
        ctrl_o.op_a_sel = OP_A_PC;
        ctrl_o.op_b_sel = OP_B_IMMEDIATE;
        ctrl_o.alu_op   = ALU_ADD;
        ctrl_o.jump     = 1'b1;
        ctrl_o.wb_sel   = WB_PC_PLUS_4;
      end
      OPC_JALR: begin
        ctrl_o.op_b_sel = OP_B_IMMEDIATE;
        ctrl_o.alu_op   = ALU_ADD;
        ctrl_o.jump     = 1'b1;
        ctrl_o.wb_sel   = WB_PC_PLUS_4;
      end
      OPC_BRANCH: begin
        imm_type_o      = IMM_B;
        ctrl_o.op_a_sel = OP_A_PC;
        ctrl_o.op_b_sel = OP_B_IMMEDIATE;
        ctrl_o.alu_op   = ALU_ADD;
        ctrl_o.branch   = 1'b1;
      end
      OPC_LOAD: begin
        ctrl_o.op_b_sel = OP_B_IMMEDIATE;
        ctrl_o.alu_op   = ALU_ADD;
        ctrl_o.mem_read = 1'b1;
        ctrl_o.wb_sel   = WB_MEMORY;
      end
      OPC_STORE: begin
        imm_type_o       = IMM_S;
        ctrl_o.op_b_sel  = OP_B_IMMEDIATE;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.mem_write = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl_o.op_b_sel = OP_B_IMMEDIATE;
        ctrl_o.alu_op   = alu_from_funct3(funct3, (funct3 == 3'b101) && instr_i[30]);
        ctrl_o.wb_sel   = WB_ALU;
        // only the shift-immediates carry a funct7 field
        bad_f7 = ((funct3 == 3'b001) && (funct7 != 7'b0000000)) ||
                 ((funct3 == 3'b101) && (funct7 != 7'b0000000) && (funct7 != 7'b0100000));
      end
      OPC_OP: begin
        ctrl_o.op_b_sel = OP_B_OPERAND_2;
        ctrl_o.alu_op   = alu_from_funct3(funct3, instr_i[30]);
        ctrl_o.wb_sel   = WB_ALU;
        bad_f7 = !((funct7 == 7'b0000000) ||
                   ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_MISC_MEM: ;
      default: bad_f7 = 1'b1;
    endcase
    if (bad_f7) begin
      ctrl_o         = ID_EX_BUBBLE;
      ctrl_o.illegal = 1'b1;
    end
    if (instr_i[11:7] == 5'd0) ctrl_o.wb_sel = WB_NONE;
  end

endmodule

// File: rtl/rv32i_decode_stage.sv
// rtl/rv32i_decode_stage.sv - decode, immediate generation, load-use hazard and ID/EX register
module rv32i_decode_stage
  import rv32i_types_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid_i,
  input  logic [31:0]                if_instr_i,
  input  logic [XLEN-1:0]            if_pc_i,
  input  logic                       flush_i,
  output logic [4:0]                 rs1_addr_o,
  output logic [4:0]                 rs2_addr_o,
  input  logic [XLEN-1:0]            rs1_data_i,
  input  logic [XLEN-1:0]            rs2_data_i,
  output logic                       stall_o,
  output logic                       ex_valid_o,
  output logic [XLEN-1:0]            ex_pc_o,
  output logic [XLEN-1:0]            ex_imm_o,
  output logic [XLEN-1:0]            ex_rs1_data_o,
  output logic [XLEN-1:0]            ex_rs2_data_o,
  output logic [4:0]                 ex_rd_o,
  output logic [2:0]                 ex_funct3_o,
  output ALU_op_options_t            ex_alu_op_o,
  output mux_ALU_operand_A_options_t ex_op_a_sel_o,
  output mux_ALU_operand_B_options_t ex_op_b_sel_o,
  output mux_writeback_options_t     ex_wb_sel_o,
  output logic                       ex_mem_read_o,
  output logic                       ex_mem_write_o,
  output logic                       ex_branch_o,
  output logic                       ex_jump_o,
  output logic                       ex_illegal_o
);

  id_ex_ctrl_t     dec_ctrl;
  imm_type_t       imm_type;
  logic [31:0]     imm;
  logic [6:0]      opcode;
  logic            rs1_used, rs2_used, hazard, insert_bubble;

  id_ex_ctrl_t     ctrl_d, ctrl_q;
  logic            valid_d, valid_q;
  logic [XLEN-1:0] pc_d, pc_q, imm_d, imm_q, rs1_d, rs1_q, rs2_d, rs2_q;
  logic [4:0]      rd_d, rd_q;
  logic [2:0]      funct3_d, funct3_q;

  rv32i_decoder u_decoder (
    .instr_i    (if_instr_i),
    .ctrl_o     (dec_ctrl),
    .imm_type_o (imm_type)
  );

  always_comb begin
    case (imm_type)
      IMM_S:   imm = {{20{if_instr_i[31]}}, if_instr_i[31:25], if_instr_i[11:7]};
      IMM_B:   imm = {{19{if_instr_i[31]}}, if_instr_i[31], if_instr_i[7],
                      if_instr_i[30:25], if_instr_i[11:8], 1'b0};
      IMM_U:   imm = {if_instr_i[31:12], 12'd0};
      IMM_J:   imm = {{11{if_instr_i[31]}}, if_instr_i[31], if_instr_i[19:12],
                      if_instr_i[20], if_instr_i[30:21], 1'b0};
      default: imm = {{20{if_instr_i[31]}}, if_instr_i[31:20]};
    endcase
  end

  assign opcode     = if_instr_i[6:0];
  assign rs1_addr_o = if_instr_i[19:15];
  assign rs2_addr_o = if_instr_i[24:20];
  assign rs1_used   = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
  assign rs2_used   = (opcode == OPC_OP) || (opcode == OPC_BRANCH) || (opcode == OPC_STORE);

  // a load in execute cannot forward in time to the instruction in decode
  assign hazard = valid_q && (ctrl_q.wb_sel == WB_MEMORY) && (rd_q != 5'd0) && if_valid_i &&
                  ((rs1_used && (rd_q == rs1_addr_o)) || (rs2_used && (rd_q == rs2_addr_o)));
  assign stall_o       = hazard && !flush_i;
  assign insert_bubble = flush_i || stall_o || !if_valid_i;

  always_comb begin
    ctrl_d   = dec_ctrl;
    valid_d  = 1'b1;
    pc_d     = if_pc_i;
    imm_d    = imm;
    rs1_d    = rs1_data_i;
    rs2_d    = rs2_data_i;
    rd_d     = if_instr_i[11:7];
    funct3_d = if_instr_i[14:12];
    if (insert_bubble) begin
      ctrl_d   = ID_EX_BUBBLE;
      valid_d  = 1'b0;
      pc_d     = '0;
      imm_d    = '0;
      rs1_d    = '0;
      rs2_d    = '0;
      rd_d     = '0;
      funct3_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= ID_EX_BUBBLE;
      valid_q  <= 1'b0;
      pc_q     <= '0;
      imm_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      funct3_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      imm_q    <= imm_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      funct3_q <= funct3_d;
    end
  end

  assign ex_valid_o     = valid_q;
  assign ex_pc_o        = pc_q;
  assign ex_imm_o       = imm_q;
  assign ex_rs1_data_o  = rs1_q;
  assign ex_rs2_data_o  = rs2_q;
  assign ex_rd_o        = rd_q;
  assign ex_funct3_o    = funct3_q;
  assign ex_alu_op_o    = ctrl_q.alu_op;
  assign ex_op_a_sel_o  = ctrl_q.op_a_sel;
  assign ex_op_b_sel_o  = ctrl_q.op_b_sel;
  assign ex_wb_sel_o    = ctrl_q.wb_sel;
  assign ex_mem_read_o  = ctrl_q.mem_read;
  assign ex_mem_write_o = ctrl_q.mem_write;
  assign ex_branch_o    = ctrl_q.branch;
  assign ex_jump_o      = ctrl_q.jump;
  assign ex_illegal_o   = ctrl_q.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// tb/tb_rv32i_decode_stage.sv - scoreboard bench for rv32i_decode_stage
module tb_rv32i_decode_stage;
  import rv32i_types_pkg::*;

  logic clk, rst, if_valid_i, flush_i, stall_o;
  logic [31:0] if_instr_i, if_pc_i, rs1_data_i, rs2_data_i;
  logic [4:0]  rs1_addr_o, rs2_addr_o, ex_rd_o;
  logic        ex_valid_o, ex_mem_read_o, ex_mem_write_o, ex_branch_o, ex_jump_o, ex_illegal_o;
  logic [31:0] ex_pc_o, ex_imm_o, ex_rs1_data_o, ex_rs2_data_o;
  logic [2:0]  ex_funct3_o;
  ALU_op_options_t            ex_alu_op_o;
  mux_ALU_operand_A_options_t ex_op_a_sel_o;
  mux_ALU_operand_B_options_t ex_op_b_sel_o;
  mux_writeback_options_t     ex_wb_sel_o;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic                       valid;
    ALU_op_options_t            alu;
    mux_ALU_operand_A_options_t opa;
    mux_ALU_operand_B_options_t opb;
    mux_writeback_options_t     wb;
    logic [31:0]                imm, pc, d1, d2;
    logic [4:0]                 rd;
    logic [2:0]                 f3;
    logic [4:0]                 fl;
  } exp_t;

  exp_t sb[$];

  rv32i_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .if_instr_i(if_instr_i),
    .if_pc_i(if_pc_i), .flush_i(flush_i), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .stall_o(stall_o),
    .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_imm_o(ex_imm_o),
    .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o), .ex_rd_o(ex_rd_o),
    .ex_funct3_o(ex_funct3_o), .ex_alu_op_o(ex_alu_op_o), .ex_op_a_sel_o(ex_op_a_sel_o),
    .ex_op_b_sel_o(ex_op_b_sel_o), .ex_wb_sel_o(ex_wb_sel_o), .ex_mem_read_o(ex_mem_read_o),
    .ex_mem_write_o(ex_mem_write_o), .ex_branch_o(ex_branch_o), .ex_jump_o(ex_jump_o),
    .ex_illegal_o(ex_illegal_o)
  );

  function automatic logic [31:0] rf(input logic [4:0] a);
    return 32'hC0DE_0000 + {27'd0, a};
  endfunction

  assign rs1_data_i = rf(rs1_addr_o);
  assign rs2_data_i = rf(rs2_addr_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
    end
  endtask

  // fl = {mem_read, mem_write, branch, jump, illegal}
  function automatic exp_t mk(input ALU_op_options_t alu, input mux_ALU_operand_A_options_t opa,
                              input mux_ALU_operand_B_options_t opb, input mux_writeback_options_t wb,
                              input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd,
                              input logic [2:0] f3, input logic [4:0] fl,
                              input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    e.valid = 1'b1; e.alu = alu; e.opa = opa; e.opb = opb; e.wb = wb;
    e.imm = imm; e.pc = pc; e.rd = rd; e.f3 = f3; e.fl = fl;
    e.d1 = rf(a1); e.d2 = rf(a2);
    return e;
  endfunction

  function automatic exp_t bub();
    exp_t e;
    e.valid = 1'b0; e.alu = ALU_NONE; e.opa = OP_A_OPERAND_1; e.opb = OP_B_OPERAND_2;
    e.wb = WB_NONE; e.imm = '0; e.pc = '0; e.rd = '0; e.f3 = '0; e.fl = '0;
    e.d1 = '0; e.d2 = '0;
    return e;
  endfunction

  task automatic step(input logic r, input logic v, input logic fl, input logic [31:0] ins,
                      input logic [31:0] pc, input logic est, input exp_t e);
    exp_t x;
    @(negedge clk);
    rst = r; if_valid_i = v; flush_i = fl; if_instr_i = ins; if_pc_i = pc;
    #1;
    check("stall", {31'd0, stall_o}, {31'd0, est});
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("valid", {31'd0, ex_valid_o}, {31'd0, x.valid});
    check("alu_op", 32'(ex_alu_op_o), 32'(x.alu));
    check("op_a", 32'(ex_op_a_sel_o), 32'(x.opa));
    check("op_b", 32'(ex_op_b_sel_o), 32'(x.opb));
    check("wb_sel", 32'(ex_wb_sel_o), 32'(x.wb));
    check("imm", ex_imm_o, x.imm);
    check("pc", ex_pc_o, x.pc);
    check("rd", {27'd0, ex_rd_o}, {27'd0, x.rd});
    check("funct3", {29'd0, ex_funct3_o}, {29'd0, x.f3});
    check("flags", {27'd0, ex_mem_read_o, ex_mem_write_o, ex_branch_o, ex_jump_o, ex_illegal_o},
          {27'd0, x.fl});
    check("rs1_data", ex_rs1_data_o, x.d1);
    check("rs2_data", ex_rs2_data_o, x.d2);
  endtask

  initial begin
    rst = 1'b1; if_valid_i = 1'b1; flush_i = 1'b0; if_instr_i = 32'h00500093; if_pc_i = 32'h100;
    step(1, 1, 0, 32'h00500093, 32'h100, 0, bub());
    step(1, 1, 0, 32'h00500093, 32'h100, 0, bub());
    step(0, 1, 0, 32'h00500093, 32'h100, 0,
         mk(ALU_ADD, OP_A_OPERAND_1, OP_B_IMMEDIATE, WB_ALU, 32'd5, 32'h100, 5'd1, 3'd0, 5'b00000, 5'd0, 5'd5));
    step(0, 1, 0, 32'h0000A103, 32'h104, 0,
         mk(ALU_ADD, OP_A_OPERAND_1, OP_B_IMMEDIATE, WB_MEMORY, 32'd0, 32'h104, 5'd2, 3'd2, 5'b10000, 5'd1, 5'd0));
    step(0, 1, 0, 32'h002101B3, 32'h108, 1, bub());
    step(0, 1, 0, 32'h002101B3, 32'h108, 0,
         mk(ALU_ADD, OP_A_OPERAND_1, OP_B_OPERAND_2, WB_ALU, 32'd2, 32'h108, 5'd3, 3'd0, 5'b00000, 5'd2, 5'd2));
    step(0, 1, 0, 32'h0000A103, 32'h10C, 0,
         mk(ALU_ADD, OP_A_OPERAND_1, OP_B_IMMEDIATE, WB_MEMORY, 32'd0, 32'h10C, 5'd2, 3'd2, 5'b10000, 5'd1, 5'd0));
    step(0, 1, 1, 32'h002101B3, 32'h110, 0, bub());
    step(0, 1, 0, 32'h40208033, 32'h200, 0,
         mk(ALU_SUB, OP_A_OPERAND_1, OP_B_OPERAND_2, WB_NONE, 32'h402, 32'h200, 5'd0, 3'd0, 5'b00000, 5'd1, 5'd2));
    step(0, 1, 0, 32'h4030D093, 32'h204, 0,
         mk(ALU_SRA, OP_A_OPERAND_1, OP_B_IMMEDIATE, WB_ALU, 32'h403, 32'h204, 5'd1, 3'd5, 5'b00000, 5'd1, 5'd3));
    step(0, 1, 0, 32'hFE000CE3, 32'h208, 0,
         mk(ALU_ADD, OP_A_PC, OP_B_IMMEDIATE, WB_NONE, 32'hFFFFFFF8, 32'h208, 5'd25, 3'd0, 5'b00100, 5'd0, 5'd0));
    step(0, 1, 0, 32'hFFFFFFFF, 32'h20C, 0,
         mk(ALU_NONE, OP_A_OPERAND_1, OP_B_OPERAND_2, WB_NONE, 32'hFFFFFFFF, 32'h20C, 5'd31, 3'd7, 5'b00001, 5'd31, 5'd31));
    step(0, 1, 0, 32'h00500013, 32'h210, 0,
         mk(ALU_ADD, OP_A_OPERAND_1, OP_B_IMMEDIATE, WB_NONE, 32'd5, 32'h210, 5'd0, 3'd0, 5'b00000, 5'd0, 5'd5));
    step(0, 1, 0, 32'h0041A283, 32'h300, 0,
         mk(ALU_ADD, OP_A_OPERAND_1, OP_B_IMMEDIATE, WB_MEMORY, 32'd4, 32'h300, 5'd5, 3'd2, 5'b10000, 5'd3, 5'd4));
    step(0, 1, 0, 32'h000283B7, 32'h304, 0,
         mk(ALU_B, OP_A_OPERAND_1, OP_B_IMMEDIATE, WB_ALU, 32'h00028000, 32'h304, 5'd7, 3'd0, 5'b00000, 5'd5, 5'd0));
    step(0, 0, 0, 32'h0000A103, 32'h308, 0, bub());
    step(1, 1, 0, 32'h00500093, 32'h30C, 0, bub());
    step(0, 1, 0, 32'h00500093, 32'h400, 0,
         mk(ALU_ADD, OP_A_OPERAND_1, OP_B_IMMEDIATE, WB_ALU, 32'd5, 32'h400, 5'd1, 3'd0, 5'b00000, 5'd0, 5'd5));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
